// File: rtl/fft_but_sched.sv
// fft_but_sched
//   Stage/address sequencer for a shared 4-dot/2-dot butterfly core running a
//   mixed-radix in-place DIF FFT over a 4-bank-addressed sample RAM. Each RUN
//   cycle issues one butterfly: four read addresses, a twiddle exponent and
//   the butterfly mode. The same addresses come back out as write-back
//   addresses LAT cycles later. A DRAIN phase of LAT cycles between stages
//   lets the last write of a stage land before the next stage reads.
//
// Ports
//   iCLK, iRESET           clock, asynchronous active-low reset
//   iSTART                 start pulse, only honoured in IDLE
//   oBUSY                  high from RUN entry through the final DRAIN cycle
//   oDONE                  one-cycle completion pulse
//   oRD_EN, oRD_ADDR0..3   read strobe and butterfly input addresses x0..x3
//   oTW_EXP                twiddle exponent e (leg m uses W_N^(e*m))
//   oBUT_SEL               0 = 4-dot butterfly, 1 = two 2-dot butterflies
//   oSTAGE                 stage index of the issued butterfly
//   oWR_EN, oWR_ADDR0..3   write strobe and result addresses y0..y3
module fft_but_sched #(
  parameter int N_LOG2 = 8,
  parameter int RD_LAT = 1,
  parameter int ST_W   = 3
) (
  input  logic              iCLK,
  input  logic              iRESET,
  input  logic              iSTART,
  output logic              oBUSY,
  output logic              oDONE,
  output logic              oRD_EN,
  output logic [N_LOG2-1:0] oRD_ADDR0,
  output logic [N_LOG2-1:0] oRD_ADDR1,
  output logic [N_LOG2-1:0] oRD_ADDR2,
  output logic [N_LOG2-1:0] oRD_ADDR3,
  output logic [N_LOG2-1:0] oTW_EXP,
  output logic              oBUT_SEL,
  output logic [ST_W-1:0]   oSTAGE,
  output logic              oWR_EN,
  output logic [N_LOG2-1:0] oWR_ADDR0,
  output logic [N_LOG2-1:0] oWR_ADDR1,
  output logic [N_LOG2-1:0] oWR_ADDR2,
  output logic [N_LOG2-1:0] oWR_ADDR3
);

  localparam int LAT    = RD_LAT + 1;        // RAM read plus butterfly register
  localparam int NUM_ST = (N_LOG2 + 1) / 2;
  localparam int NUM_R4 = N_LOG2 / 2;

  localparam logic [N_LOG2-1:0] K_LAST  = N_LOG2'((1 << (N_LOG2 - 2)) - 1);
  localparam logic [ST_W-1:0]   ST_LAST = ST_W'(NUM_ST - 1);
  localparam logic [1:0]        DR_LAST = 2'(LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic                   en;
    logic                   sel;
    logic [ST_W-1:0]        stage;
    logic [N_LOG2-1:0]      tw;
    logic [3:0][N_LOG2-1:0] addr;
  } rd_t;

  typedef struct packed {
    logic                   en;
    logic [3:0][N_LOG2-1:0] addr;
  } wr_t;

  state_t            state_q, state_d;
  logic [N_LOG2-1:0] k_q, k_d;
  logic [ST_W-1:0]   stage_q, stage_d;
  logic [1:0]        dr_q, dr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  rd_t               rd_q, rd_d;
  wr_t [LAT-1:0]     pipe_q, pipe_d;

  // Address generation scratch
  int                qlog;
  logic [N_LOG2-1:0] mask, j, g, base;

  // ---------------------------------------------------------------------------
  // Control FSM: stage / butterfly counter / drain counter
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d = state_q;
    k_d     = k_q;
    stage_d = stage_q;
    dr_d    = dr_q;
    case (state_q)
      S_IDLE: begin
        if (iSTART) begin
          state_d = S_RUN;
          k_d     = '0;
          stage_d = '0;
        end
      end
      S_RUN: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
          dr_d    = '0;
        end else begin
          k_d = k_q + N_LOG2'(1);
        end
      end
      S_DRAIN: begin
        if (dr_q == DR_LAST) begin
          if (stage_q != ST_LAST) begin
            state_d = S_RUN;
            stage_d = stage_q + ST_W'(1);
            k_d     = '0;
          end else begin
            state_d = S_DONE;
          end
        end else begin
          dr_d = dr_q + 2'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered from the next state so they line up
    // with the registered read bundle.
    busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);
  end

  // ---------------------------------------------------------------------------
  // Read bundle: computed from the next stage/k so it is valid in the first
  // RUN cycle; holds its previous contents when no butterfly is issued.
  // ---------------------------------------------------------------------------
  always_comb begin
    rd_d    = rd_q;
    rd_d.en = 1'b0;
    qlog    = 0;
    mask    = '0;
    j       = '0;
    g       = '0;
    base    = '0;
    if (state_d == S_RUN) begin
      rd_d.en    = 1'b1;
      rd_d.stage = stage_d;
      if (int'(stage_d) < NUM_R4) begin
        // Radix-4: q = 2^qlog, group g = k/q, offset j = k mod q.
        qlog = N_LOG2 - 2 - 2 * int'(stage_d);
        mask = N_LOG2'((1 << qlog) - 1);
        j    = k_d & mask;
        g    = k_d >> qlog;
        base = (g << (qlog + 2)) | j;
        for (int m = 0; m < 4; m++) begin
          rd_d.addr[m] = base + (N_LOG2'(m) << qlog);
        end
        rd_d.tw  = j << (2 * int'(stage_d));
        rd_d.sel = 1'b0;
      end else begin
        // Trailing radix-2 stage: two adjacent pairs per issue slot.
        for (int m = 0; m < 4; m++) begin
          rd_d.addr[m] = (k_d << 2) | N_LOG2'(m);
        end
        rd_d.tw  = '0;
        rd_d.sel = 1'b1;
      end
    end
  end

  // Write-back delay line: LAT-deep shift of the read strobe and addresses.
  always_comb begin
    pipe_d[0].en   = rd_q.en;
    pipe_d[0].addr = rd_q.addr;
    for (int i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // NOTE: the delay line is cleared on reset like every other flop, so a
  // reset in mid-flight can never leak a stale write strobe afterwards.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      stage_q <= '0;
      dr_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= '0;
      pipe_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      k_q     <= k_d;
      stage_q <= stage_d;
      dr_q    <= dr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      pipe_q  <= pipe_d;
    end
  end

  assign oBUSY     = busy_q;
  assign oDONE     = done_q;
  assign oRD_EN    = rd_q.en;
  assign oRD_ADDR0 = rd_q.addr[0];
  assign oRD_ADDR1 = rd_q.addr[1];
  assign oRD_ADDR2 = rd_q.addr[2];
  assign oRD_ADDR3 = rd_q.addr[3];
  assign oTW_EXP   = rd_q.tw;
  assign oBUT_SEL  = rd_q.sel;
  assign oSTAGE    = rd_q.stage;
  assign oWR_EN    = pipe_q[LAT-1].en;
  assign oWR_ADDR0 = pipe_q[LAT-1].addr[0];
  assign oWR_ADDR1 = pipe_q[LAT-1].addr[1];
  assign oWR_ADDR2 = pipe_q[LAT-1].addr[2];
  assign oWR_ADDR3 = pipe_q[LAT-1].addr[3];

endmodule

// File: tb/tb_fft_but_sched.sv
// tb_fft_but_sched
//   Three instances: A (N_LOG2=4, RD_LAT=1), B (N_LOG2=3, RD_LAT=0) and
//   C (N_LOG2=8, RD_LAT=3). Stimulus pushes hand-computed read/write/done
//   expectations for A and B into queues; a negedge monitor pops and compares
//   whenever the DUT presents a strobe. C is checked for coverage, read-to-
//   write delay, stage ordering and a few hand-computed butterflies.
module tb_fft_but_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ------------------------------------------------------------------ DUTs
  logic a_rst_n = 1'b1, b_rst_n = 1'b1, c_rst_n = 1'b1;
  logic a_start = 1'b0, b_start = 1'b0, c_start = 1'b0;

  logic       a_busy, a_done, a_rd_en, a_sel, a_wr_en;
  logic [3:0] a_rd0, a_rd1, a_rd2, a_rd3, a_tw, a_wr0, a_wr1, a_wr2, a_wr3;
  logic [2:0] a_stage;

  logic       b_busy, b_done, b_rd_en, b_sel, b_wr_en;
  logic [2:0] b_rd0, b_rd1, b_rd2, b_rd3, b_tw, b_wr0, b_wr1, b_wr2, b_wr3;
  logic [2:0] b_stage;

  logic       c_busy, c_done, c_rd_en, c_sel, c_wr_en;
  logic [7:0] c_rd0, c_rd1, c_rd2, c_rd3, c_tw, c_wr0, c_wr1, c_wr2, c_wr3;
  logic [2:0] c_stage;

  fft_but_sched #(.N_LOG2(4), .RD_LAT(1), .ST_W(3)) u_a (
    .iCLK(clk), .iRESET(a_rst_n), .iSTART(a_start),
    .oBUSY(a_busy), .oDONE(a_done), .oRD_EN(a_rd_en),
    .oRD_ADDR0(a_rd0), .oRD_ADDR1(a_rd1), .oRD_ADDR2(a_rd2), .oRD_ADDR3(a_rd3),
    .oTW_EXP(a_tw), .oBUT_SEL(a_sel), .oSTAGE(a_stage), .oWR_EN(a_wr_en),
    .oWR_ADDR0(a_wr0), .oWR_ADDR1(a_wr1), .oWR_ADDR2(a_wr2), .oWR_ADDR3(a_wr3));

  fft_but_sched #(.N_LOG2(3), .RD_LAT(0), .ST_W(3)) u_b (
    .iCLK(clk), .iRESET(b_rst_n), .iSTART(b_start),
    .oBUSY(b_busy), .oDONE(b_done), .oRD_EN(b_rd_en),
    .oRD_ADDR0(b_rd0), .oRD_ADDR1(b_rd1), .oRD_ADDR2(b_rd2), .oRD_ADDR3(b_rd3),
    .oTW_EXP(b_tw), .oBUT_SEL(b_sel), .oSTAGE(b_stage), .oWR_EN(b_wr_en),
    .oWR_ADDR0(b_wr0), .oWR_ADDR1(b_wr1), .oWR_ADDR2(b_wr2), .oWR_ADDR3(b_wr3));

  fft_but_sched #(.N_LOG2(8), .RD_LAT(3), .ST_W(3)) u_c (
    .iCLK(clk), .iRESET(c_rst_n), .iSTART(c_start),
    .oBUSY(c_busy), .oDONE(c_done), .oRD_EN(c_rd_en),
    .oRD_ADDR0(c_rd0), .oRD_ADDR1(c_rd1), .oRD_ADDR2(c_rd2), .oRD_ADDR3(c_rd3),
    .oTW_EXP(c_tw), .oBUT_SEL(c_sel), .oSTAGE(c_stage), .oWR_EN(c_wr_en),
    .oWR_ADDR0(c_wr0), .oWR_ADDR1(c_wr1), .oWR_ADDR2(c_wr2), .oWR_ADDR3(c_wr3));

  // ------------------------------------------------- expectation tables
  // Row: {cycle offset from iSTART cycle, stage, but_sel, a0, a1, a2, a3, tw}
  localparam int A_TAB [8][8] = '{
    '{ 1, 0, 0,  0,  4,  8, 12, 0},
    '{ 2, 0, 0,  1,  5,  9, 13, 1},
    '{ 3, 0, 0,  2,  6, 10, 14, 2},
    '{ 4, 0, 0,  3,  7, 11, 15, 3},
    '{ 7, 1, 0,  0,  1,  2,  3, 0},
    '{ 8, 1, 0,  4,  5,  6,  7, 0},
    '{ 9, 1, 0,  8,  9, 10, 11, 0},
    '{10, 1, 0, 12, 13, 14, 15, 0}};
  localparam int B_TAB [4][8] = '{
    '{1, 0, 0, 0, 2, 4, 6, 0},
    '{2, 0, 0, 1, 3, 5, 7, 1},
    '{4, 1, 1, 0, 1, 2, 3, 0},
    '{5, 1, 1, 4, 5, 6, 7, 0}};
  // Per instance A/B: read latency to write, done offset, last busy offset
  localparam int LAT_TB   [2] = '{2, 1};
  localparam int DONE_OFF [2] = '{13, 7};
  localparam int BUSY_END [2] = '{12, 6};
  // C spot checks: {stage, k, a0, a1, a2, a3, tw}
  localparam int C_SPOT [4][7] = '{
    '{0,  1,  1, 65, 129, 193,  1},
    '{1, 17, 65, 81,  97, 113,  4},
    '{2,  6, 18, 22,  26,  30, 32},
    '{3,  5, 20, 21,  22,  23,  0}};

  typedef struct {
    int cyc;
    int st;
    int sel;
    int a0, a1, a2, a3;
    int tw;
  } rec_t;

  rec_t rq [2][$];
  rec_t wq [2][$];
  int   dq [2][$];
  int   bf [2] = '{1, 1};
  int   bt [2] = '{0, 0};

  task automatic push_exp(input int d, input int t0);
    int   nrow;
    int   r [8];
    rec_t e;
    nrow = (d == 0) ? 8 : 4;
    for (int i = 0; i < nrow; i++) begin
      for (int c = 0; c < 8; c++) r[c] = (d == 0) ? A_TAB[i][c] : B_TAB[i % 4][c];
      e.cyc = t0 + r[0]; e.st = r[1]; e.sel = r[2];
      e.a0 = r[3]; e.a1 = r[4]; e.a2 = r[5]; e.a3 = r[6]; e.tw = r[7];
      rq[d].push_back(e);
      e.cyc = e.cyc + LAT_TB[d];
      wq[d].push_back(e);
    end
    dq[d].push_back(t0 + DONE_OFF[d]);
    bf[d] = t0 + 1;
    bt[d] = t0 + BUSY_END[d];
  endtask

  task automatic mon(input int d, input logic busy, input logic done,
                     input logic rd_en, input int r0, input int r1, input int r2,
                     input int r3, input int tw, input int sel, input int st,
                     input logic wr_en, input int w0, input int w1, input int w2,
                     input int w3);
    string nm;
    rec_t  e;
    int    t;
    nm = (d == 0) ? "A" : "B";
    check({nm, " busy"}, busy, (cyc >= bf[d]) && (cyc <= bt[d]));
    if (rd_en) begin
      check({nm, " rd expected"}, rq[d].size() != 0, 1);
      if (rq[d].size() != 0) begin
        e = rq[d].pop_front();
        check({nm, " rd cycle"}, cyc, e.cyc);
        check({nm, " rd addr0"}, r0, e.a0);
        check({nm, " rd addr1"}, r1, e.a1);
        check({nm, " rd addr2"}, r2, e.a2);
        check({nm, " rd addr3"}, r3, e.a3);
        check({nm, " tw_exp"}, tw, e.tw);
        check({nm, " but_sel"}, sel, e.sel);
        check({nm, " stage"}, st, e.st);
      end
    end
    if (wr_en) begin
      check({nm, " wr expected"}, wq[d].size() != 0, 1);
      if (wq[d].size() != 0) begin
        e = wq[d].pop_front();
        check({nm, " wr cycle"}, cyc, e.cyc);
        check({nm, " wr addr0"}, w0, e.a0);
        check({nm, " wr addr1"}, w1, e.a1);
        check({nm, " wr addr2"}, w2, e.a2);
        check({nm, " wr addr3"}, w3, e.a3);
      end
    end
    if (done) begin
      check({nm, " done expected"}, dq[d].size() != 0, 1);
      if (dq[d].size() != 0) begin
        t = dq[d].pop_front();
        check({nm, " done cycle"}, cyc, t);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, a_busy, a_done, a_rd_en, int'(a_rd0), int'(a_rd1), int'(a_rd2),
        int'(a_rd3), int'(a_tw), int'(a_sel), int'(a_stage), a_wr_en,
        int'(a_wr0), int'(a_wr1), int'(a_wr2), int'(a_wr3));
    mon(1, b_busy, b_done, b_rd_en, int'(b_rd0), int'(b_rd1), int'(b_rd2),
        int'(b_rd3), int'(b_tw), int'(b_sel), int'(b_stage), b_wr_en,
        int'(b_wr0), int'(b_wr1), int'(b_wr2), int'(b_wr3));
  end

  // ------------------------------------------------------------ C monitor
  typedef struct {
    int cyc;
    int st;
    int a0, a1, a2, a3;
  } c_rec_t;

  c_rec_t c_pend [$];
  int c_rd_cnt [4][256];
  int c_wr_cnt [4][256];
  int c_wr_bfly [4] = '{0, 0, 0, 0};
  int c_k [4] = '{0, 0, 0, 0};
  int c_done_n = 0;
  int c_busy_n = 0;
  int c_t0 = -1000;

  initial begin
    for (int s = 0; s < 4; s++)
      for (int a = 0; a < 256; a++) begin
        c_rd_cnt[s][a] = 0;
        c_wr_cnt[s][a] = 0;
      end
  end

  always @(negedge clk) begin
    c_rec_t e;
    int     s;
    if (c_busy) c_busy_n++;
    if (c_rd_en) begin
      s = int'(c_stage);
      check("C stage range", s < 4, 1);
      if (s < 4) begin
        if (s > 0) check("C rd after prev stage writes", c_wr_bfly[s-1], 64);
        c_rd_cnt[s][c_rd0]++;
        c_rd_cnt[s][c_rd1]++;
        c_rd_cnt[s][c_rd2]++;
        c_rd_cnt[s][c_rd3]++;
        for (int i = 0; i < 4; i++) begin
          if (C_SPOT[i][0] == s && C_SPOT[i][1] == c_k[s]) begin
            check("C spot addr0", c_rd0, C_SPOT[i][2]);
            check("C spot addr1", c_rd1, C_SPOT[i][3]);
            check("C spot addr2", c_rd2, C_SPOT[i][4]);
            check("C spot addr3", c_rd3, C_SPOT[i][5]);
            check("C spot tw_exp", c_tw, C_SPOT[i][6]);
            check("C spot but_sel", c_sel, 0);
          end
        end
        c_k[s]++;
        e.cyc = cyc + 4; e.st = s;
        e.a0 = int'(c_rd0); e.a1 = int'(c_rd1); e.a2 = int'(c_rd2); e.a3 = int'(c_rd3);
        c_pend.push_back(e);
      end
    end
    if (c_wr_en) begin
      check("C wr expected", c_pend.size() != 0, 1);
      if (c_pend.size() != 0) begin
        e = c_pend.pop_front();
        check("C wr delay", cyc, e.cyc);
        check("C wr addr0", c_wr0, e.a0);
        check("C wr addr1", c_wr1, e.a1);
        check("C wr addr2", c_wr2, e.a2);
        check("C wr addr3", c_wr3, e.a3);
        c_wr_cnt[e.st][c_wr0]++;
        c_wr_cnt[e.st][c_wr1]++;
        c_wr_cnt[e.st][c_wr2]++;
        c_wr_cnt[e.st][c_wr3]++;
        c_wr_bfly[e.st]++;
      end
    end
    if (c_done) begin
      c_done_n++;
      check("C done cycle", cyc, c_t0 + 273);
    end
  end

  // -------------------------------------------------------------- stimulus
  task automatic wait_cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Called just after a rising edge; holds iSTART for exactly one cycle.
  task automatic go(input int d);
    case (d)
      0:       a_start = 1'b1;
      1:       b_start = 1'b1;
      default: c_start = 1'b1;
    endcase
    wait_cyc(1);
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
  endtask

  initial begin
    int bad;
    #2;
    a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
    wait_cyc(3);
    check("A reset outputs", {a_busy, a_done, a_rd_en, a_rd0, a_rd1, a_rd2, a_rd3,
          a_tw, a_sel, a_stage, a_wr_en, a_wr0, a_wr1, a_wr2, a_wr3}, 0);
    check("B reset outputs", {b_busy, b_done, b_rd_en, b_rd0, b_rd1, b_rd2, b_rd3,
          b_tw, b_sel, b_stage, b_wr_en, b_wr0, b_wr1, b_wr2, b_wr3}, 0);
    check("C reset rd side", {c_busy, c_done, c_rd_en, c_rd0, c_rd1, c_rd2, c_rd3,
          c_tw, c_sel, c_stage}, 0);
    check("C reset wr side", {c_wr_en, c_wr0, c_wr1, c_wr2, c_wr3}, 0);
    a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;
    wait_cyc(2);

    // A: full run, with iSTART pulsed during RUN and in the DONE cycle.
    push_exp(0, cyc);
    go(0);                 // now in cycle t0+1
    wait_cyc(1);           // cycle t0+2 (RUN)
    go(0);                 // now t0+3
    wait_cyc(10);          // cycle t0+13 (DONE)
    go(0);                 // now t0+14, back in IDLE
    wait_cyc(5);

    // A: fresh start in IDLE runs normally.
    push_exp(0, cyc);
    go(0);
    wait_cyc(18);

    // A: reset in the middle of the stage-0 DRAIN (cycle t0+5).
    push_exp(0, cyc);
    go(0);                 // now t0+1
    wait_cyc(4);           // now t0+5, before this cycle's sample point
    a_rst_n = 1'b0;
    #1;
    check("A async reset outputs", {a_busy, a_done, a_rd_en, a_rd0, a_rd1, a_rd2, a_rd3,
          a_tw, a_sel, a_stage, a_wr_en, a_wr0, a_wr1, a_wr2, a_wr3}, 0);
    rq[0].delete();
    wq[0].delete();
    dq[0].delete();
    bf[0] = 1;
    bt[0] = 0;
    wait_cyc(2);
    a_rst_n = 1'b1;
    wait_cyc(20);          // any write, read or done here is unexpected
    push_exp(0, cyc);
    go(0);
    wait_cyc(18);

    // B: odd N_LOG2 with trailing radix-2 stage, zero RAM latency.
    push_exp(1, cyc);
    go(1);
    wait_cyc(12);

    // C: long run with deep read latency.
    c_t0 = cyc;
    go(2);
    wait_cyc(290);

    for (int d = 0; d < 2; d++) begin
      check("A/B reads outstanding", rq[d].size(), 0);
      check("A/B writes outstanding", wq[d].size(), 0);
      check("A/B done outstanding", dq[d].size(), 0);
    end
    check("C done count", c_done_n, 1);
    check("C busy cycles", c_busy_n, 272);
    check("C writes outstanding", c_pend.size(), 0);
    for (int s = 0; s < 4; s++) begin
      bad = 0;
      for (int a = 0; a < 256; a++) if (c_rd_cnt[s][a] != 1) bad++;
      check($sformatf("C stage %0d read coverage errors", s), bad, 0);
      bad = 0;
      for (int a = 0; a < 256; a++) if (c_wr_cnt[s][a] != 1) bad++;
      check($sformatf("C stage %0d write coverage errors", s), bad, 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/fft_but_sched.md
Name: fft_but_sched

Overview:
- Stage/address sequencer for the shared 4-dot/2-dot butterfly core (1-cycle registered, iBUT_SEL-selectable).
- Runs a mixed-radix in-place DIF FFT over a 4-bank-addressed sample RAM.
- Each cycle it issues one butterfly's four read addresses, the twiddle exponent and the butterfly mode.
- It also issues the matching delayed write-back addresses, draining the pipeline between stages to avoid read-after-write hazards.

Parameters:
- N_LOG2, 8: log2 of FFT length N. Legal range 2..12.
- RD_LAT, 1: sample RAM read latency in cycles. Legal range 0..3.
- ST_W, 3: width of the stage index. Must satisfy 2^ST_W ≥ NUM_ST.

Ports:
- iCLK  in  1  clock.
- iRESET  in  1  reset.
- iSTART  in  1  start pulse; sampled only in IDLE.
- oBUSY  out  1  high from RUN entry through the final DRAIN cycle.
- oDONE  out  1  one-cycle pulse on FFT completion.
- oRD_EN  out  1  read strobe, one butterfly per cycle.
- oRD_ADDR0..oRD_ADDR3  out  N_LOG2 each  butterfly input addresses x0..x3.
- oTW_EXP  out  N_LOG2  twiddle exponent e. Downstream applies W_N^(e·m) to leg m=1..3.
- oBUT_SEL  out  1  0 = 4-dot, 1 = 2-dot pairs.
- oSTAGE  out  ST_W  current stage index.
- oWR_EN  out  1  write strobe for the butterfly result.
- oWR_ADDR0..oWR_ADDR3  out  N_LOG2 each  result addresses y0..y3.

Behaviour:
- Reset is asynchronous and active-low on iRESET; clock is iCLK.
- While iRESET is low: all outputs 0, FSM in IDLE, delay line cleared. This holds mid-operation too: in-flight writes are discarded and no oDONE is generated.
- Derived constants:
  - LAT = RD_LAT + 1 (RAM read plus the butterfly register).
  - NUM_ST = ceil(N_LOG2/2).
  - NUM_R4 = floor(N_LOG2/2).
- Stages 0..NUM_R4-1 are radix-4 (oBUT_SEL=0). If N_LOG2 is odd, stage NUM_R4 is radix-2 (oBUT_SEL=1).
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN when iSTART=1; stage=0, k=0.
  - RUN: one butterfly per cycle, k = 0..N/4-1. After k = N/4-1, go to DRAIN.
  - DRAIN: lasts exactly LAT cycles. Then, if stage < NUM_ST-1: stage++, k=0, RUN. Otherwise go to DONE.
  - DONE: oDONE=1 for one cycle, oBUSY=0, then IDLE.
- iSTART outside IDLE (RUN, DRAIN, DONE) is ignored and is not queued.
- Radix-4 addressing, stage s:
  - q = N >> (2s+2); g = k / q; j = k mod q (shift/mask only).
  - base = 4·g·q + j.
  - ADDRm = base + m·q, for m = 0..3.
  - oTW_EXP = j << (2s).
- Radix-2 stage addressing: ADDRm = 4k + m; oTW_EXP = 0.
- All RD outputs (oRD_EN, addresses, oTW_EXP, oBUT_SEL, oSTAGE) are registered and valid in the same cycle. They hold their last value when oRD_EN=0.
- Write side is a LAT-deep shift of {oRD_EN, oRD_ADDR0..3}, giving oWR_EN/oWR_ADDRm exactly LAT cycles after the matching read.
- The last write of stage s lands in the last DRAIN cycle. The first read of stage s+1 follows on the next cycle.
- Total busy cycles = NUM_ST·(N/4 + LAT).

Test Plan:
- N_LOG2=4, RD_LAT=1, iSTART at cycle 0:
  - stage-0 reads in cycles 1–4, writes in cycles 3–6, DRAIN in cycles 5–6;
  - stage-1 reads in cycles 7–10;
  - oDONE=1 in cycle 13 only; oBUSY high in cycles 1–12.
- N_LOG2=4 address check:
  - stage 0, k=1 → addresses 1,5,9,13, oTW_EXP=1;
  - stage 1, k=2 → addresses 8,9,10,11, oTW_EXP=0, oBUT_SEL=0.
- N_LOG2=3, RD_LAT=0:
  - stage 0, k=1 → addresses 1,3,5,7, oTW_EXP=1;
  - stage 1 has oBUT_SEL=1; k=1 → addresses 4,5,6,7;
  - oDONE at cycle 2·(2+1)+1 = 7.
- iSTART pulsed during RUN and again in the DONE cycle → no restart, a single oDONE. A fresh iSTART in IDLE afterwards runs normally.
- iRESET low mid-stage-0 DRAIN → all outputs 0 immediately (asynchronous), no oWR_EN afterwards, no oDONE. After release and iSTART, the sequence matches the first scenario exactly.
- N_LOG2=8, RD_LAT=3: over the whole run, every address 0..255 is read and written exactly once per stage. Writes match reads delayed by 4 cycles, and no read of stage s+1 occurs before the last write of stage s.
